// File: rtl/core_bus_pkg.sv
// Shared types and constants for the two-master, one-slave bus arbiter.
package core_bus_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_IDLE  = 2'b00;
  localparam logic [1:0] GRANT_INSTR = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  // On a tie the master that was not served last wins; last_d=1 means data went last.
  function automatic state_t rr_select(input logic req_i, input logic req_d, input logic last_d);
    if (req_i && req_d) return last_d ? GNT_I : GNT_D;
    if (req_i)          return GNT_I;
    if (req_d)          return GNT_D;
    return IDLE;
  endfunction

endpackage

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data masters.
// Define ARB_TIMEOUT_EN to add a watchdog that errors out a grant stuck without ack.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    i_cyc,
  input  logic                    i_stb,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ack,
  output logic                    i_err,
  input  logic                    d_cyc,
  input  logic                    d_stb,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ack,
  output logic                    d_err,
  output logic                    m_cyc,
  output logic                    m_stb,
  output logic                    m_we,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ack,
  output logic [1:0]              grant_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("core_bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t state, state_next;
  logic   last_d, last_d_next;
  logic   req_i, req_d;
  logic   timeout_hit;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_next;
      last_d <= last_d_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] timeout_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                                 timeout_cnt <= '0;
    else if (state == IDLE || state_next == IDLE) timeout_cnt <= '0;
    else                                        timeout_cnt <= timeout_cnt + 16'd1;
  end

  assign timeout_hit = (timeout_cnt == TIMEOUT_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    req_i       = i_cyc & i_stb;
    req_d       = d_cyc & d_stb;
    state_next  = state;
    last_d_next = last_d;
    m_cyc       = 1'b0;
    m_stb       = 1'b0;
    m_we        = 1'b0;
    m_wstrb     = '0;
    m_addr      = '0;
    m_wdata     = '0;
    i_rdata     = '0;
    i_ack       = 1'b0;
    i_err       = 1'b0;
    d_rdata     = '0;
    d_ack       = 1'b0;
    d_err       = 1'b0;
    grant_o     = GRANT_IDLE;

    unique case (state)
      IDLE: state_next = rr_select(req_i, req_d, last_d);

      GNT_I: begin
        grant_o = GRANT_INSTR;
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_wstrb = i_wstrb;
        m_addr  = i_addr;
        m_wdata = i_wdata;
        i_ack   = m_ack;
        i_rdata = m_rdata;
        // An abort leaves fairness untouched; a completed or timed-out transfer counts as served.
        if (!i_cyc) begin
          state_next = IDLE;
        end else if (m_ack || timeout_hit) begin
          state_next  = IDLE;
          last_d_next = 1'b0;
          i_err       = timeout_hit & ~m_ack;
        end
      end

      GNT_D: begin
        grant_o = GRANT_DATA;
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_wstrb = d_wstrb;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        d_ack   = m_ack;
        d_rdata = m_rdata;
        if (!d_cyc) begin
          state_next = IDLE;
        end else if (m_ack || timeout_hit) begin
          state_next  = IDLE;
          last_d_next = 1'b1;
          d_err       = timeout_hit & ~m_ack;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: memory responder model plus an ack scoreboard.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_core_bus_arbiter;
  import core_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          i_cyc, i_stb, i_we, i_ack, i_err;
  logic [SW-1:0] i_wstrb;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata, i_rdata;
  logic          d_cyc, d_stb, d_we, d_ack, d_err;
  logic [SW-1:0] d_wstrb;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_cyc, m_stb, m_we, m_ack;
  logic [SW-1:0] m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    grant_o;

  logic          resp_ack   = 1'b0;
  logic          late_ack   = 1'b0;
  logic [DW-1:0] resp_rdata = '0;
  int            mem_delay  = 1;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_d[$];
  bit            order_q[$];
  logic [1:0]    trace_q[$];

  assign m_ack   = resp_ack | late_ack;
  assign m_rdata = resp_rdata;

  always #5 sys_clk = ~sys_clk;

  core_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_wstrb(i_wstrb), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .grant_o(grant_o)
  );

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h0C0D};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Memory slave: acks after mem_delay strobed cycles (0 = never), one-cycle ack pulse.
  initial begin : memory_model
    int wait_cnt = 0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (resp_ack || !(m_cyc && m_stb)) begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (mem_delay > 0 && wait_cnt >= mem_delay) resp_ack = 1'b1;
      end
      resp_rdata = resp_ack ? mem_model(m_addr) : '0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic score_acks();
    logic [1:0]    exp_owner;
    logic [DW-1:0] exp_data;
    if (i_ack || d_ack) begin
      exp_owner = 2'b00;
      if (order_q.size() > 0) exp_owner = order_q.pop_front() ? GRANT_DATA : GRANT_INSTR;
      check("ack_owner", {d_ack, i_ack}, exp_owner);
      if (i_ack) begin
        exp_data = 'x;
        if (exp_i.size() > 0) exp_data = exp_i.pop_front();
        check("i_rdata", i_rdata, exp_data);
        check("d_rdata_quiet", d_rdata, '0);
      end
      if (d_ack) begin
        exp_data = 'x;
        if (exp_d.size() > 0) exp_data = exp_d.pop_front();
        check("d_rdata", d_rdata, exp_data);
        check("i_rdata_quiet", i_rdata, '0);
      end
    end
  endtask

  // Masters keep requesting until n_i / n_d transfers complete; records grant_o changes.
  task automatic run_masters(input int n_i, input int n_d, input int budget);
    int         i_left = n_i;
    int         d_left = n_d;
    int         cycles = 0;
    bit         i_done, d_done;
    logic [1:0] prev   = GRANT_IDLE;
    trace_q.delete();
    while ((i_left > 0 || d_left > 0) && cycles < budget) begin
      @(negedge sys_clk);
      cycles++;
      if (grant_o != prev) begin
        trace_q.push_back(grant_o);
        prev = grant_o;
      end
      i_done = i_ack;
      d_done = d_ack;
      score_acks();
      @(posedge sys_clk);
      #1;
      if (i_done && i_left > 0) begin
        i_left--;
        if (i_left > 0) begin
          i_addr = i_addr + 32'h4;
          exp_i.push_back(mem_model(i_addr));
        end else begin
          i_cyc = 1'b0;
          i_stb = 1'b0;
        end
      end
      if (d_done && d_left > 0) begin
        d_left--;
        if (d_left > 0) begin
          d_addr = d_addr + 32'h4;
          exp_d.push_back(mem_model(d_addr));
        end else begin
          d_cyc = 1'b0;
          d_stb = 1'b0;
        end
      end
    end
    check("run_within_budget", (i_left == 0 && d_left == 0), 1'b1);
  endtask

  initial begin : stimulus
    logic [1:0] exp_trace [7] = '{GRANT_INSTR, GRANT_IDLE, GRANT_DATA, GRANT_IDLE,
                                  GRANT_INSTR, GRANT_IDLE, GRANT_DATA};
    bit got;
    int stb_cycle, err_cycle, err_count, d_err_count, hold_breaks;
    bit d_after;

    {i_cyc, i_stb, i_we} = '0; i_wstrb = '0; i_addr = '0; i_wdata = '0;
    {d_cyc, d_stb, d_we} = '0; d_wstrb = '0; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (2) @(negedge sys_clk);
    check("rst_grant", grant_o, GRANT_IDLE);
    check("rst_m_cyc", m_cyc, 1'b0);
    check("rst_m_stb", m_stb, 1'b0);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_errs", {i_err, d_err}, 2'b00);
    rst_n = 1'b1;

    // Single instruction read with one-cycle memory response
    @(posedge sys_clk); #1;
    mem_delay = 1;
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h0000_0100;
    exp_i.push_back(mem_model(32'h0000_0100));
    order_q.push_back(1'b0);
    @(negedge sys_clk);
    check("t1_arb_cycle_m_stb", m_stb, 1'b0);
    check("t1_arb_cycle_grant", grant_o, GRANT_IDLE);
    @(negedge sys_clk);
    check("t1_m_stb", m_stb, 1'b1);
    check("t1_grant", grant_o, GRANT_INSTR);
    check("t1_m_addr", m_addr, 32'h0000_0100);
    check("t1_i_ack", i_ack, 1'b1);
    check("t1_d_ack", d_ack, 1'b0);
    score_acks();
    @(posedge sys_clk); #1;
    i_cyc = 1'b0; i_stb = 1'b0;
    @(negedge sys_clk);
    check("t1_grant_release", grant_o, GRANT_IDLE);
    check("t1_i_ack_low", i_ack, 1'b0);

    // Data write held on the memory port until ack
    @(posedge sys_clk); #1;
    mem_delay = 3;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_wstrb = 4'h3;
    d_addr = 32'h0000_2000; d_wdata = 32'h0000_1234;
    exp_d.push_back(mem_model(32'h0000_2000));
    order_q.push_back(1'b1);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge sys_clk);
      if (grant_o == GRANT_DATA) begin
        check("t2_m_we", m_we, 1'b1);
        check("t2_m_wstrb", m_wstrb, 4'h3);
        check("t2_m_addr", m_addr, 32'h0000_2000);
        check("t2_m_wdata", m_wdata, 32'h0000_1234);
      end
      if (d_ack) got = 1'b1;
      score_acks();
    end
    check("t2_ack_seen", got, 1'b1);
    @(posedge sys_clk); #1;
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_wstrb = '0; d_wdata = '0;

    // Abort of a data grant, then a late ack
    mem_delay = 0;
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h0000_3000;
    repeat (2) @(negedge sys_clk);
    check("t3_d_granted", grant_o, GRANT_DATA);
    @(posedge sys_clk); #1;
    d_cyc = 1'b0; d_stb = 1'b0;
    @(negedge sys_clk);
    check("t3_abort_m_cyc", m_cyc, 1'b0);
    @(negedge sys_clk);
    check("t3_abort_idle", grant_o, GRANT_IDLE);
    late_ack = 1'b1;
    #1;
    check("t3_late_ack_d", d_ack, 1'b0);
    check("t3_late_ack_i", i_ack, 1'b0);
    late_ack = 1'b0;

    // Abort of an instruction grant must not count as service either
    @(posedge sys_clk); #1;
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h0000_3100;
    repeat (2) @(negedge sys_clk);
    check("t3_i_granted", grant_o, GRANT_INSTR);
    @(posedge sys_clk); #1;
    i_cyc = 1'b0; i_stb = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("t3_i_abort_idle", grant_o, GRANT_IDLE);

    // Tie after both aborts still favours instruction
    @(posedge sys_clk); #1;
    mem_delay = 1;
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h0000_0400;
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h0000_0800;
    exp_i.push_back(mem_model(32'h0000_0400));
    exp_d.push_back(mem_model(32'h0000_0800));
    order_q.push_back(1'b0);
    order_q.push_back(1'b1);
    run_masters(1, 1, 20);

    // Reset asserted in the middle of a data grant
    @(posedge sys_clk); #1;
    mem_delay = 0;
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h0000_4000;
    repeat (2) @(negedge sys_clk);
    check("t4_d_granted", grant_o, GRANT_DATA);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_m_cyc", m_cyc, 1'b0);
    check("t4_async_grant", grant_o, GRANT_IDLE);
    check("t4_async_d_ack", d_ack, 1'b0);
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h0000_0500;
    d_addr = 32'h0000_0900;
    @(negedge sys_clk);
    check("t4_reset_hold_grant", grant_o, GRANT_IDLE);
    check("t4_reset_hold_m_stb", m_stb, 1'b0);
    exp_i.push_back(mem_model(32'h0000_0500));
    exp_d.push_back(mem_model(32'h0000_0900));
    order_q.push_back(1'b0);
    order_q.push_back(1'b1);
    order_q.push_back(1'b0);
    order_q.push_back(1'b1);
    mem_delay = 2;
    rst_n = 1'b1;

    // Round robin under continuous contention, two-cycle memory
    run_masters(2, 2, 60);
    check("t5_trace_len", trace_q.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < trace_q.size()) check($sformatf("t5_trace_%0d", k), trace_q[k], exp_trace[k]);
    end
    @(negedge sys_clk);
    check("t5_final_idle", grant_o, GRANT_IDLE);
    check("t5_scoreboard_empty", order_q.size() + exp_i.size() + exp_d.size(), 0);

    // Memory never acks: watchdog (if built) or indefinite hold
    @(posedge sys_clk); #1;
    mem_delay = 0;
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h0000_0600;
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h0000_0700;
    stb_cycle = -1; err_cycle = -1; err_count = 0; d_err_count = 0; hold_breaks = 0;
    d_after = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (stb_cycle < 0 && m_stb && grant_o == GRANT_INSTR) stb_cycle = c;
      if (i_err) begin
        err_count++;
        err_cycle = c;
      end
      if (d_err) d_err_count++;
      if (err_cycle >= 0 && grant_o == GRANT_DATA) d_after = 1'b1;
      if (c >= 1 && grant_o != GRANT_INSTR) hold_breaks++;
    end
`ifdef ARB_TIMEOUT_EN
    check("t6_i_err_pulses", err_count, 1);
    check("t6_err_delay", err_cycle - stb_cycle, 4);
    check("t6_grant_to_d", d_after, 1'b1);
`else
    check("t6_stb_cycle", stb_cycle, 1);
    check("t6_no_i_err", err_count, 0);
    check("t6_grant_held", hold_breaks, 0);
`endif
    check("t6_no_d_err", d_err_count, 0);
    @(posedge sys_clk); #1;
    i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("t6_final_idle", grant_o, GRANT_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
